xorexpand_serializer: RTL and testbench

Downstream stage of the XOR-expand pseudo-random generator. It captures one expanded mask vector (RNDSIZE*(RNDSIZE-1)/2 bits) through a valid/ready handshake and streams it out as OUT_W-bit words, LSB first, through a second valid/ready handshake. It feeds the narrow mask consumers (garbling and segment-masking logic) without forcing them to hold the full-width vector.

---
 rtl/xorexpand_serializer.sv | 92 +++++++++
 tb/tb_xorexpand_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/xorexpand_serializer.sv
// rtl/xorexpand_serializer.sv - captures one expanded mask vector and streams it out LSB-first as OUT_W-bit words
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake for in_data (PW bits, bit k = k-th expander output)
//   abort                 synchronous drop of the current vector, back to IDLE
//   out_valid/out_ready   output handshake for out_data (OUT_W bits)
//   out_last              current word is the final word of the vector
//   busy                  high while a vector is being sent
module xorexpand_serializer #(
    parameter  int RNDSIZE = 16,
    parameter  int OUT_W   = 8,
    localparam int PW      = RNDSIZE * (RNDSIZE - 1) / 2,
    localparam int NWORDS  = (PW + OUT_W - 1) / OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int TOTW = NWORDS * OUT_W;
    localparam int CW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [TOTW-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic out_hs;
    logic last_acc;
    logic capture;

    // The current word always sits in the low OUT_W bits of the shift
    // register; the register is cleared whenever the block goes idle so
    // out_data reads zero outside SEND.
    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q == S_SEND);
    assign out_data  = shreg_q[OUT_W-1:0];
    assign out_last  = out_valid && (cnt_q == CW'(NWORDS - 1));

    assign out_hs   = out_valid && out_ready;
    assign last_acc = out_hs && out_last;

    // Accepting the final word frees the register in the same cycle, which
    // lets a waiting vector load with no idle bubble between vectors.
    assign in_ready = (state_q == S_IDLE) || (last_acc && !abort);
    assign capture  = in_valid && in_ready && !abort;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (capture) begin
            state_d = S_SEND;
            shreg_d = TOTW'(in_data);
            cnt_d   = '0;
        end else if (last_acc) begin
            state_d = S_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (out_hs) begin
            shreg_d = shreg_q >> OUT_W;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xorexpand_serializer.sv
// tb/tb_xorexpand_serializer.sv - scoreboard bench for xorexpand_serializer
module tb_xorexpand_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, abort, out_valid, out_ready, out_last, busy;
    logic [119:0] in_data;
    logic [7:0]   out_data;

    logic         s_in_valid, s_in_ready, s_abort, s_out_valid, s_out_ready, s_out_last, s_busy;
    logic [5:0]   s_in_data;
    logic [3:0]   s_out_data;

    int checks   = 0;
    int failures = 0;

    logic [8:0] sb[$];
    logic [4:0] ssb[$];

    xorexpand_serializer #(.RNDSIZE(16), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    xorexpand_serializer #(.RNDSIZE(4), .OUT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .abort(s_abort),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_last(s_out_last), .busy(s_busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every accepted output word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_word", {out_last, out_data}, 9'h1ff);
            else chk("word", {out_last, out_data}, sb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            if (ssb.size() == 0) chk("s_unexpected_word", {s_out_last, s_out_data}, 5'h1f);
            else chk("s_word", {s_out_last, s_out_data}, ssb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [119:0] v);
        for (int n = 0; n < 15; n++) sb.push_back({(n == 14), v[n*8 +: 8]});
    endtask

    task automatic capture(input logic [119:0] v);
        in_data  = v;
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) break;
            step();
        end
        chk("in_ready_before_capture", in_ready, 1);
        step();
        in_valid = 0;
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 100 && out_valid; i++) step();
        chk("idle_after_stream", out_valid, 0);
    endtask

    int n, ncap;
    logic vld, capt;
    logic [7:0] hold_d;
    logic hold_l;

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; abort = 0; out_ready = 0;
        s_in_valid = 0; s_in_data = '0; s_abort = 0; s_out_ready = 1;
        step(); step();
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);

        // Small instance: PW=6, two 4-bit words, pad bits zero.
        ssb.push_back({1'b0, 4'b1101});
        ssb.push_back({1'b1, 4'b0010});
        s_in_data = 6'b101101; s_in_valid = 1;
        chk("s_in_ready", s_in_ready, 1);
        step();
        s_in_valid = 0;
        chk("s_w0_valid", s_out_valid, 1);
        chk("s_w0_data", s_out_data, 4'b1101);
        chk("s_w0_last", s_out_last, 0);
        step();
        chk("s_w1_data", s_out_data, 4'b0010);
        chk("s_w1_last", s_out_last, 1);
        step();
        chk("s_done_valid", s_out_valid, 0);
        chk("s_done_busy", s_busy, 0);

        // Seed 16'h0001 expansion: bits 14:0 set.
        sb.push_back({1'b0, 8'hFF});
        sb.push_back({1'b0, 8'h7F});
        for (int k = 2; k < 15; k++) sb.push_back({(k == 14), 8'h00});
        out_ready = 1;
        capture(120'h7FFF);
        chk("seed_first_valid", out_valid, 1);
        chk("seed_first_data", out_data, 8'hFF);
        chk("seed_busy", busy, 1);
        n = 0;
        for (int i = 0; i < 20 && out_valid; i++) begin
            n++;
            step();
        end
        chk("seed_word_cycles", n, 15);

        // Backpressure pattern 1,0,0,1,...
        push_vec(120'h0F1E2D3C4B5A69788796A5B4C3D2E1);
        capture(120'h0F1E2D3C4B5A69788796A5B4C3D2E1);
        n = 0;
        for (int p = 0; p < 100 && out_valid; p++) begin
            out_ready = (p % 4 == 0) || (p % 4 == 3);
            #1;
            chk("stall_in_ready", in_ready, out_ready && out_last);
            if (!out_ready) begin
                hold_d = out_data; hold_l = out_last;
                step();
                chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, hold_l, hold_d});
            end else begin
                n++;
                step();
            end
        end
        chk("stall_word_count", n, 15);
        out_ready = 1;

        // Back-to-back vectors, no bubble.
        push_vec(120'h112233445566778899AABBCCDDEEFF);
        push_vec(~120'h112233445566778899AABBCCDDEEFF);
        capture(120'h112233445566778899AABBCCDDEEFF);
        in_data = ~120'h112233445566778899AABBCCDDEEFF;
        in_valid = 1;
        n = 0; ncap = 0;
        for (int i = 0; i < 30; i++) begin
            vld  = out_valid;
            capt = in_valid && in_ready;
            if (vld) n++;
            step();
            if (capt) begin
                in_valid = 0;
                ncap++;
            end
        end
        chk("b2b_valid_cycles", n, 30);
        chk("b2b_captures", ncap, 1);
        chk("b2b_idle_after", out_valid, 0);

        // Abort after word 3 is accepted.
        push_vec(120'h0123456789ABCDEF0123456789ABCD);
        capture(120'h0123456789ABCDEF0123456789ABCD);
        step(); step(); step(); step();
        out_ready = 0; abort = 1;
        #1;
        chk("abort_in_ready_send", in_ready, 0);
        step();
        abort = 0;
        sb.delete();
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_data", {out_last, out_data}, 0);
        in_valid = 1; in_data = 120'h1; abort = 1;
        step();
        abort = 0; in_valid = 0;
        chk("abort_wins_idle", out_valid, 0);
        out_ready = 1;
        push_vec(120'h1);
        capture(120'h1);
        chk("post_abort_word0", out_data, 8'h01);
        run_until_idle();

        // Asynchronous reset mid-stream.
        push_vec(120'hFEDCBA9876543210FEDCBA98765432);
        capture(120'hFEDCBA9876543210FEDCBA98765432);
        step(); step();
        #3;
        rst_n = 0;
        #1;
        chk("arst_outputs", {out_valid, out_last, busy, out_data}, 0);
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        step();
        chk("arst_stays_idle", out_valid, 0);

        chk("sb_empty", sb.size(), 0);
        chk("ssb_empty", ssb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
